// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit line encoder.
package usb_tx_pkg;

    localparam int CLKS_PER_BIT_DEF = 8;
    localparam int STUFF_LIMIT_DEF  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    // Line states as {d_plus, d_minus}.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [1:0] nrzi_line(input logic level);
        return level ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-slot counter: counts 0..CLKS_PER_BIT-1 while enabled, tc marks the last
// cycle of each slot.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB FS transmit encoder: paces bits, NRZI-encodes, bit-stuffs and appends EOP.
// Define USB_TX_BIT_STUFF_EN to enable bit stuffing; otherwise runs of 1s go out unstuffed.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_start,
    input  logic serial_in,
    input  logic last_bit,
    output logic shift_en,
    output logic d_plus,
    output logic d_minus,
    output logic tx_busy
);

    tx_state_e  state_q, state_d;
    logic       nrzi_q, nrzi_d;
    logic [1:0] line_q, line_d;
    logic       shift_en_q, shift_en_d;
    logic       last_q, last_d;
    logic       se0_second_q, se0_second_d;
    logic       slot_tc, boundary, timer_clr;
    logic       sample, eop_go;

`ifdef USB_TX_BIT_STUFF_EN
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);
    logic [ONES_W-1:0] ones_q, ones_d;
`else
    localparam int unused_stuff_limit = STUFF_LIMIT;
`endif

    assign timer_clr = (state_q == ST_IDLE);
    assign boundary  = slot_tc || (timer_clr && tx_start);

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .n_rst(n_rst),
        .clr  (timer_clr),
        .en   (!timer_clr),
        .tc   (slot_tc)
    );

    // State names the slot currently on the line; last_q remembers whether the
    // bit in flight (or the one that caused the stuff) ends the packet.
    always_comb begin
        state_d      = state_q;
        nrzi_d       = nrzi_q;
        line_d       = line_q;
        shift_en_d   = 1'b0;
        last_d       = last_q;
        se0_second_d = se0_second_q;
        sample       = 1'b0;
        eop_go       = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
        ones_d       = ones_q;
`endif
        if (boundary) begin
            case (state_q)
                ST_IDLE: sample = 1'b1;
                ST_DATA: begin
`ifdef USB_TX_BIT_STUFF_EN
                    if (ones_q == ONES_MAX) begin
                        state_d = ST_STUFF;
                        nrzi_d  = ~nrzi_q;
                        line_d  = nrzi_line(~nrzi_q);
                        ones_d  = '0;
                    end else
`endif
                    if (last_q) eop_go = 1'b1;
                    else        sample = 1'b1;
                end
                ST_STUFF: begin
                    if (last_q) eop_go = 1'b1;
                    else        sample = 1'b1;
                end
                ST_EOP_SE0: begin
                    if (se0_second_q) begin
                        state_d = ST_EOP_J;
                        line_d  = LINE_J;
                        nrzi_d  = 1'b1;
                    end else begin
                        se0_second_d = 1'b1;
                    end
                end
                ST_EOP_J: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase

            if (sample) begin
                state_d    = ST_DATA;
                nrzi_d     = serial_in ? nrzi_q : ~nrzi_q;
                line_d     = nrzi_line(serial_in ? nrzi_q : ~nrzi_q);
                last_d     = last_bit;
                shift_en_d = 1'b1;
`ifdef USB_TX_BIT_STUFF_EN
                ones_d     = serial_in ? ones_q + 1'b1 : '0;
`endif
            end

            if (eop_go) begin
                state_d      = ST_EOP_SE0;
                line_d       = LINE_SE0;
                se0_second_d = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
                ones_d       = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            nrzi_q       <= 1'b1;
            line_q       <= LINE_J;
            shift_en_q   <= 1'b0;
            last_q       <= 1'b0;
            se0_second_q <= 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
            ones_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            nrzi_q       <= nrzi_d;
            line_q       <= line_d;
            shift_en_q   <= shift_en_d;
            last_q       <= last_d;
            se0_second_q <= se0_second_d;
`ifdef USB_TX_BIT_STUFF_EN
            ones_q       <= ones_d;
`endif
        end
    end

    assign d_plus   = line_q[1];
    assign d_minus  = line_q[0];
    assign shift_en = shift_en_q;
    assign tx_busy  = (state_q != ST_IDLE) || tx_start;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: per-cycle line/shift_en/busy against a
// slot-level model of NRZI, stuffing and EOP built from the packet's bit list.
module tb_usb_tx_encoder;

    localparam int CPB = 8;
    localparam int LIM = 6;
`ifdef USB_TX_BIT_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    logic clk       = 1'b0;
    logic n_rst     = 1'b0;
    logic tx_start  = 1'b0;
    logic serial_in = 1'b0;
    logic last_bit  = 1'b0;
    logic shift_en, d_plus, d_minus, tx_busy;

    int checks = 0;
    int errors = 0;

    bit         pkt_bits[$];
    logic [1:0] exp_line[$];
    bit         exp_se[$];
    bit         exp_busy[$];
    logic [1:0] obs_line[$];
    bit         obs_se[$];
    bit         obs_busy[$];

    usb_tx_encoder #(
        .CLKS_PER_BIT(CPB),
        .STUFF_LIMIT (LIM)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (tx_start),
        .serial_in(serial_in),
        .last_bit (last_bit),
        .shift_en (shift_en),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected waveform: entry 0 is the tx_start cycle, then one entry per cycle
    // of every slot, then one idle slot afterwards.
    function automatic void build_expected();
        logic [1:0] slot_line[$];
        bit         slot_data[$];
        bit         lvl = 1'b1;
        int         run = 0;
        exp_line.delete(); exp_se.delete(); exp_busy.delete();
        foreach (pkt_bits[i]) begin
            if (!pkt_bits[i]) lvl = !lvl;
            slot_line.push_back(lvl ? 2'b10 : 2'b01);
            slot_data.push_back(1'b1);
            run = pkt_bits[i] ? run + 1 : 0;
            if (STUFF_ON && run == LIM) begin
                lvl = !lvl;
                slot_line.push_back(lvl ? 2'b10 : 2'b01);
                slot_data.push_back(1'b0);
                run = 0;
            end
        end
        slot_line.push_back(2'b00); slot_data.push_back(1'b0);
        slot_line.push_back(2'b00); slot_data.push_back(1'b0);
        slot_line.push_back(2'b10); slot_data.push_back(1'b0);
        exp_line.push_back(2'b10); exp_se.push_back(1'b0); exp_busy.push_back(1'b1);
        foreach (slot_line[s]) begin
            for (int k = 0; k < CPB; k++) begin
                exp_line.push_back(slot_line[s]);
                exp_se.push_back(slot_data[s] && (k == 0));
                exp_busy.push_back(1'b1);
            end
        end
        for (int k = 0; k < CPB; k++) begin
            exp_line.push_back(2'b10); exp_se.push_back(1'b0); exp_busy.push_back(1'b0);
        end
    endfunction

    // Plays the byte register: presents pkt_bits one at a time, advancing on shift_en.
    task automatic capture(input int pulse_at);
        int idx = 0;
        int n = pkt_bits.size();
        obs_line.delete(); obs_se.delete(); obs_busy.delete();
        serial_in = pkt_bits[0];
        last_bit  = (n == 1);
        @(negedge clk);
        tx_start = 1'b1;
        #1;
        obs_line.push_back({d_plus, d_minus}); obs_se.push_back(shift_en); obs_busy.push_back(tx_busy);
        for (int c = 1; c < exp_line.size(); c++) begin
            @(negedge clk);
            obs_line.push_back({d_plus, d_minus}); obs_se.push_back(shift_en); obs_busy.push_back(tx_busy);
            if (shift_en) idx++;
            serial_in = (idx < n) ? pkt_bits[idx] : 1'b0;
            last_bit  = (idx == n - 1);
            tx_start  = (c == pulse_at);
        end
        tx_start = 1'b0;
    endtask

    task automatic load_sync();
        pkt_bits.delete();
        for (int i = 0; i < 7; i++) pkt_bits.push_back(1'b0);
        pkt_bits.push_back(1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({d_plus, d_minus} !== 2'b10) begin
            errors++; $display("FAIL reset_line: got %b expected 10", {d_plus, d_minus});
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy);
        end
        checks++;
        if (shift_en !== 1'b0) begin
            errors++; $display("FAIL reset_shift_en: got %b expected 0", shift_en);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset: line=%b busy=%b shift_en=%b", {d_plus, d_minus}, tx_busy, shift_en);
    endtask

    task automatic test_sync();
        load_sync();
        build_expected();
        capture(-1);
        for (int i = 0; i < exp_line.size(); i++) begin
            checks++;
            if ({obs_line[i], obs_se[i], obs_busy[i]} !== {exp_line[i], exp_se[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL sync cycle %0d: line/shift_en/busy got %b/%b/%b expected %b/%b/%b",
                         i, obs_line[i], obs_se[i], obs_busy[i], exp_line[i], exp_se[i], exp_busy[i]);
                break;
            end
        end
        $display("test_sync: %0d bits, %0d cycles compared", pkt_bits.size(), exp_line.size());
    endtask

    task automatic test_stuff_ff();
        load_sync();
        for (int i = 0; i < 8; i++) pkt_bits.push_back(1'b1);
        build_expected();
        capture(-1);
        for (int i = 0; i < exp_line.size(); i++) begin
            checks++;
            if ({obs_line[i], obs_se[i], obs_busy[i]} !== {exp_line[i], exp_se[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL stuff_ff cycle %0d: line/shift_en/busy got %b/%b/%b expected %b/%b/%b",
                         i, obs_line[i], obs_se[i], obs_busy[i], exp_line[i], exp_se[i], exp_busy[i]);
                break;
            end
        end
        $display("test_stuff_ff: %0d bits, %0d cycles compared", pkt_bits.size(), exp_line.size());
    endtask

    task automatic test_trailing_ones();
        load_sync();
        pkt_bits.push_back(1'b0);
        pkt_bits.push_back(1'b1);
        pkt_bits.push_back(1'b0);
        for (int i = 0; i < 6; i++) pkt_bits.push_back(1'b1);
        build_expected();
        capture(-1);
        for (int i = 0; i < exp_line.size(); i++) begin
            checks++;
            if ({obs_line[i], obs_se[i], obs_busy[i]} !== {exp_line[i], exp_se[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL trailing_ones cycle %0d: line/shift_en/busy got %b/%b/%b expected %b/%b/%b",
                         i, obs_line[i], obs_se[i], obs_busy[i], exp_line[i], exp_se[i], exp_busy[i]);
                break;
            end
        end
        $display("test_trailing_ones: %0d bits, %0d cycles compared", pkt_bits.size(), exp_line.size());
    endtask

    task automatic test_reset_mid_packet();
        serial_in = 1'b0;
        last_bit  = 1'b0;
        @(negedge clk); tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        repeat (19) @(negedge clk);
        checks++;
        if ({d_plus, d_minus} !== 2'b01) begin
            errors++; $display("FAIL mid_packet_pre_reset_line: got %b expected 01", {d_plus, d_minus});
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({d_plus, d_minus} !== 2'b10) begin
            errors++; $display("FAIL mid_reset_line: got %b expected 10", {d_plus, d_minus});
        end
        checks++;
        if ({tx_busy, shift_en} !== 2'b00) begin
            errors++; $display("FAIL mid_reset_busy_shift: got %b expected 00", {tx_busy, shift_en});
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({d_plus, d_minus, tx_busy} !== 3'b100) begin
            errors++; $display("FAIL post_reset_idle: line/busy got %b expected 100", {d_plus, d_minus, tx_busy});
        end
        load_sync();
        build_expected();
        capture(-1);
        for (int i = 0; i < exp_line.size(); i++) begin
            checks++;
            if ({obs_line[i], obs_se[i], obs_busy[i]} !== {exp_line[i], exp_se[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL after_reset cycle %0d: line/shift_en/busy got %b/%b/%b expected %b/%b/%b",
                         i, obs_line[i], obs_se[i], obs_busy[i], exp_line[i], exp_se[i], exp_busy[i]);
                break;
            end
        end
        $display("test_reset_mid_packet: reset in slot 2, then %0d-bit packet", pkt_bits.size());
    endtask

    task automatic test_start_during_eop();
        int nslots;
        load_sync();
        pkt_bits.push_back(1'b1);
        pkt_bits.push_back(1'b0);
        build_expected();
        nslots = (exp_line.size() - 1 - CPB) / CPB;
        capture((nslots - 3) * CPB + 4);
        for (int i = 0; i < exp_line.size(); i++) begin
            checks++;
            if ({obs_line[i], obs_se[i], obs_busy[i]} !== {exp_line[i], exp_se[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL start_in_eop cycle %0d: line/shift_en/busy got %b/%b/%b expected %b/%b/%b",
                         i, obs_line[i], obs_se[i], obs_busy[i], exp_line[i], exp_se[i], exp_busy[i]);
                break;
            end
        end
        $display("test_start_during_eop: tx_start pulsed in first SE0 slot");
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            int n = $urandom_range(1, 24);
            pkt_bits.delete();
            for (int i = 0; i < n; i++) pkt_bits.push_back($urandom_range(0, 3) != 0);
            build_expected();
            capture(-1);
            for (int i = 0; i < exp_line.size(); i++) begin
                checks++;
                if ({obs_line[i], obs_se[i], obs_busy[i]} !== {exp_line[i], exp_se[i], exp_busy[i]}) begin
                    errors++;
                    $display("FAIL random%0d cycle %0d: line/shift_en/busy got %b/%b/%b expected %b/%b/%b",
                             p, i, obs_line[i], obs_se[i], obs_busy[i], exp_line[i], exp_se[i], exp_busy[i]);
                    break;
                end
            end
            $display("test_random packet %0d: %0d bits, %0d cycles compared", p, n, exp_line.size());
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_stuff_ff();
        test_trailing_ones();
        test_reset_mid_packet();
        test_start_during_eop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
